// File: rtl/fmult_seq.sv
// fmult_seq: sequential IEEE-754-style multiplier.
// Significands are multiplied by shift-add, one multiplier bit per clock.
// The product is then normalised and rounded to nearest-even in a single
// cycle. Denormal inputs are flushed to zero and results never go subnormal.
module fmult_seq #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23,
   localparam int W     = 1 + EXP_W + FRAC_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out
);

   localparam int SW   = FRAC_W + 1;       // significand width incl. hidden bit
   localparam int PW   = 2 * SW;           // full product width
   localparam int CW   = $clog2(SW + 1);   // counter holds 0..SW
   localparam int EW   = EXP_W + 2;        // signed exponent arithmetic width
   localparam int BIAS = (1 << (EXP_W - 1)) - 1;
   localparam int EMAX = (1 << EXP_W) - 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MULT = 2'd1;
   localparam logic [1:0] S_NORM = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]    state;
   logic [W-1:0]  a_r, b_r;
   logic [SW-1:0] mcand;
   logic [PW-1:0] acc;
   logic [CW-1:0] cnt;
   logic [SW:0]   step_sum;

   // operand fields
   logic              sign_a, sign_b, sign_p;
   logic [EXP_W-1:0]  ea, eb;
   logic [FRAC_W-1:0] fa, fb;
   logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

   // normalise / round
   logic                 msb;
   logic [PW-1:0]        pn;
   logic [FRAC_W-1:0]    frac_t, frac_fin;
   logic                 guard, sticky, rnd;
   logic [FRAC_W:0]      frac_sum;
   logic signed [EW-1:0] e_base, e_norm, e_fin;
   logic [W-1:0]         result;

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);

   // Control FSM. MULT spends its first cycle loading significands (cnt==0),
   // then SW shift-add cycles; NORM is one cycle; DONE waits for out_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (in_valid) state <= S_MULT;
            S_MULT: if (cnt == CW'(SW)) state <= S_NORM;
            S_NORM: state <= S_DONE;
            S_DONE: if (out_ready) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // One shift-add step: add multiplicand to the upper half when the current
   // multiplier bit (held in acc[0]) is set, then shift the whole thing right.
   always_comb begin
      step_sum = {1'b0, acc[PW-1:SW]} + (acc[0] ? {1'b0, mcand} : {(SW+1){1'b0}});
   end

   // Operand capture and the iterative multiplier.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r   <= '0;
         b_r   <= '0;
         mcand <= '0;
         acc   <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_r <= a;
                  b_r <= b;
                  cnt <= '0;
               end
            end
            S_MULT: begin
               cnt <= cnt + CW'(1);
               if (cnt == '0) begin
                  mcand <= {1'b1, a_r[FRAC_W-1:0]};
                  acc   <= {{SW{1'b0}}, 1'b1, b_r[FRAC_W-1:0]};
               end else begin
                  acc <= {step_sum, acc[SW-1:1]};
               end
            end
            default: ;
         endcase
      end
   end

   // Classify operands.
   always_comb begin
      sign_a = a_r[W-1];
      sign_b = b_r[W-1];
      ea     = a_r[W-2 -: EXP_W];
      eb     = b_r[W-2 -: EXP_W];
      fa     = a_r[FRAC_W-1:0];
      fb     = b_r[FRAC_W-1:0];
      sign_p = sign_a ^ sign_b;
      a_zero = (ea == '0);
      b_zero = (eb == '0);
      a_inf  = (ea == '1) && (fa == '0);
      b_inf  = (eb == '1) && (fb == '0);
      a_nan  = (ea == '1) && (fa != '0);
      b_nan  = (eb == '1) && (fb != '0);
   end

   // Normalise, round to nearest-even, then resolve specials and range.
   always_comb begin
      e_base   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - $signed(EW'(BIAS));
      msb      = acc[PW-1];
      pn       = msb ? acc : {acc[PW-2:0], 1'b0};
      e_norm   = e_base + $signed({{(EW-1){1'b0}}, msb});
      frac_t   = pn[PW-2 -: FRAC_W];
      guard    = pn[FRAC_W];
      sticky   = |pn[FRAC_W-1:0];
      rnd      = guard & (sticky | frac_t[0]);
      frac_sum = {1'b0, frac_t} + {{FRAC_W{1'b0}}, rnd};
      // carry out of rounding means the significand became 2.0: bump exponent
      e_fin    = e_norm + $signed({{(EW-1){1'b0}}, frac_sum[FRAC_W]});
      frac_fin = frac_sum[FRAC_W] ? {FRAC_W{1'b0}} : frac_sum[FRAC_W-1:0];

      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
         result = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
      else if (a_inf || b_inf)
         result = {sign_p, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      else if (a_zero || b_zero)
         result = {sign_p, {(W-1){1'b0}}};
      else if (e_fin >= $signed(EW'(EMAX)))
         result = {sign_p, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      else if (e_fin <= $signed(EW'(0)))
         result = {sign_p, {(W-1){1'b0}}};
      else
         result = {sign_p, e_fin[EXP_W-1:0], frac_fin};
   end

   // Result register: loaded on leaving NORM, held through DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out <= '0;
      else if (state == S_NORM) out <= result;
   end

endmodule

// File: doc/fmult_seq.md
FMULT_SEQ -- requirements
Module: fmult_seq

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (>=3).
REQ-002 SHALL have parameter FRAC_W, default 23, stored fraction width (>=2); word width W = 1+EXP_W+FRAC_W.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operands a, b present.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  W  operand A: {sign, exponent, fraction}, IEEE-754-style.
REQ-008 SHALL have port b  input  W  operand B, same format.
REQ-009 SHALL have port out_valid  output  1  result on out is valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out  output  W  product a*b, same format.

Function
REQ-012 SHALL run the FSM states IDLE, MULT, NORM, DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE; a handshake (in_valid & in_ready) captures a and b and moves the FSM to MULT.
REQ-014 SHALL form significands with the hidden bit ({1,frac}, FRAC_W+1 bits) and multiply by shift-add, one multiplier bit per cycle, FRAC_W+1 cycles in MULT, into a 2*(FRAC_W+1)-bit product.
REQ-015 SHALL spend 1 cycle in NORM, then enter DONE with out_valid=1; fixed latency: out_valid rises on the FRAC_W+3rd rising edge after the accepting edge (26 for defaults), special cases included.
REQ-016 SHALL hold out and out_valid stable in DONE until out_valid & out_ready, then return to IDLE on that edge; no new operand is accepted in that same cycle.
REQ-017 SHALL compute sign = sign_a XOR sign_b for all results, NaN excepted.
REQ-018 SHALL compute the exponent in EXP_W+2-bit signed arithmetic: e = ea + eb - BIAS, BIAS = 2^(EXP_W-1)-1.
REQ-019 SHALL normalise: if product MSB=1, shift right 1 and add 1 to e.
REQ-020 SHALL round to nearest, ties to even, using guard bit and sticky OR of all lower bits; a rounding carry-out renormalises (e+1, fraction 0).
REQ-021 SHALL output signed infinity (exp all ones, frac 0) when final e >= 2^EXP_W-1.
REQ-022 SHALL output signed zero when final e <= 0 (no subnormal outputs).
REQ-023 SHALL treat inputs with exponent 0 as signed zero (flush denormals).
REQ-024 SHALL return canonical NaN {0, all ones, MSB-only fraction} when either input is NaN or for inf*zero.
REQ-025 SHALL return signed infinity for inf*finite-nonzero, and signed zero for zero*finite.
REQ-026 SHALL ignore in_valid, a and b outside IDLE.

Reset
REQ-027 SHALL, on rst_n=0 at any time including mid-MULT/DONE, immediately force state IDLE, in_ready=1 after release, out_valid=0, out=0, and clear the accumulator and counter; the in-flight operation is discarded.
REQ-028 SHALL accept a new operand on the first rising edge after rst_n deasserts if in_valid=1.

Verification
REQ-029 SHALL check a=0x3FC00000 (1.5), b=0x40000000 (2.0) -> out=0x40400000, out_valid exactly 26 edges after acceptance; a=0xC0000000, b=0x40400000 -> 0xC0C00000.
REQ-030 SHALL check rounding: a=b=0x3F800001 -> 0x3F800002; a=b=0x3FFFFFFF -> 0x407FFFFE.
REQ-031 SHALL check overflow/underflow: 0x7F000000*0x7F000000 -> 0x7F800000; 0x00800000*0x00800000 -> 0x00000000; 0x80000000*0x40000000 -> 0x80000000.
REQ-032 SHALL check specials: 0x7F800000*0x00000000 -> 0x7FC00000; 0x7FC00001*0x3F800000 -> 0x7FC00000; 0xFF800000*0x40000000 -> 0xFF800000.
REQ-033 SHALL check back-pressure: out_ready=0 for 10 cycles after out_valid -> out and out_valid held, in_ready=0; in_valid toggled with other operands meanwhile has no effect.
REQ-034 SHALL check rst_n pulsed low at cycle 10 of MULT -> out_valid=0, out=0 at once; next operand 1.5*2.0 completes correctly with 26-edge latency.
REQ-035 SHALL re-run REQ-029 with EXP_W=5, FRAC_W=10 (half): 0x3E00*0x4000 -> 0x4200, latency 13 edges.
